// File: rtl/serial_prog_receiver_pkg.sv
// Shared definitions for the FPGA programming link: opcode field widths and receiver state encoding.
package serial_prog_receiver_pkg;

    localparam int unsigned SPR_GAINA1_W = 2;
    localparam int unsigned SPR_GAINA2_W = 3;
    localparam int unsigned SPR_NBITS    = SPR_GAINA1_W + SPR_GAINA2_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } spr_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous level with a rising-edge pulse on the synced value.
module sync_edge_detect #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic rise_c
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        prev_d = sync_q[STAGES-1];
    end

    // Reset to the idle level so reset release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/serial_prog_receiver.sv
// Chip-side receiver: oversamples the serial programming link, assembles an LSB-first frame and presents gain opcodes.
module serial_prog_receiver
    import serial_prog_receiver_pkg::*;
#(
    parameter int unsigned NBITS       = SPR_NBITS,
    parameter int unsigned GAINA1_W    = SPR_GAINA1_W,
    parameter int unsigned GAINA2_W    = SPR_GAINA2_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                i_mainclk,
    input  logic                i_reset,
    input  logic                i_sclk,
    input  logic                i_sdin,
    output logic [GAINA1_W-1:0] o_gainA1,
    output logic [GAINA2_W-1:0] o_gainA2,
    output logic                o_ready,
    output logic                o_err
);

    localparam int unsigned BCNT_W = $clog2(NBITS + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

    logic                   sclk_rise;
    logic [SYNC_STAGES-1:0] sdin_sync_q, sdin_sync_d;
    logic                   sdin_s;

    spr_state_e             state_q, state_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic [NBITS-1:0]       sreg_q, sreg_d;
    logic [NBITS-1:0]       shifted;
    logic [GAINA1_W-1:0]    gain_a1_q, gain_a1_d;
    logic [GAINA2_W-1:0]    gain_a2_q, gain_a2_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;

    sync_edge_detect #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sclk_sync (
        .clk    (i_mainclk),
        .rst    (i_reset),
        .d_in   (i_sclk),
        .rise_c (sclk_rise)
    );

    // Data path uses the same depth so the synced bit lines up with the detected edge.
    assign sdin_s = sdin_sync_q[SYNC_STAGES-1];

    always_comb begin
        sdin_sync_d = {sdin_sync_q[SYNC_STAGES-2:0], i_sdin};
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        tcnt_d      = tcnt_q;
        sreg_d      = sreg_q;
        gain_a1_d   = gain_a1_q;
        gain_a2_d   = gain_a2_q;
        ready_d     = ready_q;
        err_d       = err_q;
        shifted     = {sdin_s, sreg_q[NBITS-1:1]};

        case (state_q)
            S_IDLE: begin
                if (sclk_rise) begin
                    sreg_d  = shifted;
                    bcnt_d  = BCNT_W'(1);
                    tcnt_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sclk_rise) begin
                    sreg_d = shifted;
                    tcnt_d = '0;
                    if (bcnt_q == BCNT_W'(NBITS - 1)) begin
                        bcnt_d    = BCNT_W'(NBITS);
                        state_d   = S_DONE;
                        gain_a1_d = shifted[GAINA1_W-1:0];
                        gain_a2_d = shifted[NBITS-1:GAINA1_W];
                        ready_d   = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end else if (tcnt_q >= TCNT_W'(TIMEOUT - 1)) begin
                    // Stalled partial frame: drop it and flag the link.
                    state_d = S_IDLE;
                    bcnt_d  = '0;
                    tcnt_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_DONE: begin
                if (sclk_rise) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                bcnt_d  = '0;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_mainclk or posedge i_reset) begin
        if (i_reset) begin
            sdin_sync_q <= '0;
            state_q     <= S_IDLE;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            sreg_q      <= '0;
            gain_a1_q   <= '0;
            gain_a2_q   <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sdin_sync_q <= sdin_sync_d;
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            tcnt_q      <= tcnt_d;
            sreg_q      <= sreg_d;
            gain_a1_q   <= gain_a1_d;
            gain_a2_q   <= gain_a2_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    assign o_gainA1 = gain_a1_q;
    assign o_gainA2 = gain_a2_q;
    assign o_ready  = ready_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_serial_prog_receiver.sv
// Bench for serial_prog_receiver: directed link scenarios plus randomized frames against a frame-level model.
module tb_serial_prog_receiver;

    localparam int NB = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       sdin;
    logic [1:0] g1;
    logic [2:0] g2;
    logic       rdy;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Frame-level model: received bits, frame-complete flag, sticky error, decoded gains.
    int m_bits[$];
    int m_g1, m_g2, m_rdy, m_err;

    always #5 clk = ~clk;

    serial_prog_receiver dut (
        .i_mainclk (clk),
        .i_reset   (rst),
        .i_sclk    (sclk),
        .i_sdin    (sdin),
        .o_gainA1  (g1),
        .o_gainA2  (g2),
        .o_ready   (rdy),
        .o_err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_bits.delete();
        m_g1 = 0; m_g2 = 0; m_rdy = 0; m_err = 0;
    endtask

    task automatic model_bit(input int b);
        int val;
        if (m_rdy != 0) begin
            m_err = 1;
        end else begin
            m_bits.push_back(b);
            if (m_bits.size() == NB) begin
                val = 0;
                foreach (m_bits[i]) val += m_bits[i] << i;
                m_g1  = val % 4;
                m_g2  = val / 4;
                m_rdy = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; sclk = 1'b1; sdin = 1'b0;
        cycles(3);
        rst = 1'b0;
        model_clear();
        cycles(2);
    endtask

    // One bit: low phase with data set up, then high phase; noisy toggles sdin once safely past the edge.
    task automatic send_bit(input int b, input int ph, input bit noisy);
        sclk = 1'b0; sdin = b[0];
        cycles(ph);
        sclk = 1'b1;
        if (noisy) begin
            cycles(3);
            repeat (ph - 3) begin
                sdin = ~sdin;
                cycles(1);
            end
        end else begin
            cycles(ph);
        end
        model_bit(b);
    endtask

    task automatic idle(input int n);
        sclk = 1'b1;
        cycles(n);
        if (n >= 64 && m_rdy == 0 && m_bits.size() > 0) begin
            m_err = 1;
            m_bits.delete();
        end
    endtask

    task automatic send_frame(input int bits[5], input int ph, input bit noisy);
        for (int i = 0; i < NB; i++) send_bit(bits[i], ph, noisy);
    endtask

    task automatic check_all(input string tag);
        cycles(2);
        chk({tag, ".gainA1"}, 32'(g1), 32'(m_g1));
        chk({tag, ".gainA2"}, 32'(g2), 32'(m_g2));
        chk({tag, ".ready"},  32'(rdy), 32'(m_rdy));
        chk({tag, ".err"},    32'(err), 32'(m_err));
    endtask

    initial begin
        int f[5];
        rst = 1'b1; sclk = 1'b1; sdin = 1'b0;
        model_clear();
        cycles(3);
        rst = 1'b0;

        // Reset release with sclk idle high: no spurious edge.
        idle(100);
        check_all("rst_idle");

        // Basic frame, with latency check around the final edge.
        f = '{1, 0, 1, 0, 1};
        for (int i = 0; i < NB - 1; i++) send_bit(f[i], 8, 1'b0);
        sclk = 1'b0; sdin = 1'b1;
        cycles(8);
        sclk = 1'b1;
        cycles(2);
        chk("lat.ready_early", 32'(rdy), 32'd0);
        chk("lat.gain_early", 32'(g1), 32'd0);
        cycles(2);
        chk("lat.ready_4cyc", 32'(rdy), 32'd1);
        cycles(4);
        model_bit(f[NB-1]);
        check_all("frame10101");

        // Extra edge after a complete frame.
        send_bit(0, 8, 1'b0);
        check_all("extra_edge");

        // Partial frame then timeout, then a good frame with sticky error.
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(1, 8, 1'b0);
        idle(30);
        check_all("pre_timeout");
        idle(80);
        check_all("timeout");
        f = '{0, 1, 1, 1, 1};
        send_frame(f, 8, 1'b0);
        check_all("after_timeout");

        // Async reset mid-operation clears outputs without a clock edge.
        do_reset();
        f = '{1, 0, 1, 0, 1};
        send_frame(f, 6, 1'b0);
        send_bit(1, 6, 1'b0);
        check_all("pre_async");
        send_bit(1, 6, 1'b0);
        sclk = 1'b0;
        cycles(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async.ready", 32'(rdy), 32'd0);
        chk("async.err",   32'(err), 32'd0);
        chk("async.g1",    32'(g1),  32'd0);
        sclk = 1'b1;
        cycles(3);
        rst = 1'b0;
        model_clear();
        cycles(2);
        f = '{1, 1, 0, 0, 1};
        send_frame(f, 8, 1'b0);
        check_all("after_async");

        // Noisy data while sclk high.
        do_reset();
        f = '{1, 0, 1, 0, 1};
        send_frame(f, 8, 1'b1);
        check_all("noisy");

        // Randomized trials: random bit counts, phases, noise and stalls.
        for (int t = 0; t < 16; t++) begin
            do_reset();
            for (int i = 0, n = int'($urandom_range(0, 7)); i < n; i++) begin
                send_bit(int'($urandom_range(0, 1)), int'($urandom_range(4, 10)),
                         1'($urandom_range(0, 1)));
                if ($urandom_range(0, 4) == 0) idle(80);
                else idle(int'($urandom_range(0, 15)));
            end
            check_all($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_prog_receiver.md
Name: serial_prog_receiver

Overview:
Chip-side receiver for the FPGA programming link: consumes the serial clock/data pair driven by the FPGA model and assembles the amplifier gain opcodes. Oversamples i_sclk/i_sdin on the chip main clock, shifts a fixed-length LSB-first frame, then presents gainA1/gainA2 to the analog front end and raises o_ready back to the FPGA. Includes an inter-edge timeout and an error flag for malformed frames.

Parameters:
NBITS, 5, frame length in bits; must equal GAINA1_W + GAINA2_W
GAINA1_W, 2, width of amplifier-1 gain opcode
GAINA2_W, 3, width of amplifier-2 gain opcode
SYNC_STAGES, 2, synchroniser depth on i_sclk and i_sdin, minimum 2
TIMEOUT, 64, mainclk cycles without an sclk rising edge that abort a partial frame

Ports:
i_mainclk  input  1  chip main clock; sole clock
i_reset  input  1  asynchronous, active-high reset
i_sclk  input  1  serial clock from FPGA; idles high; asynchronous to i_mainclk
i_sdin  input  1  serial data from FPGA; valid at i_sclk rising edge
o_gainA1  output  GAINA1_W  amplifier-1 gain opcode
o_gainA2  output  GAINA2_W  amplifier-2 gain opcode
o_ready  output  1  high when a complete frame is loaded
o_err  output  1  sticky error: timeout or extra sclk edge

Behaviour:
- Reset (async, i_reset=1): o_gainA1=0, o_gainA2=0, o_ready=0, o_err=0, state=sIDLE, bit counter=0, timeout counter=0, shift register=0. Both synchroniser chains reset to 1 for sclk and 0 for sdin, so no false edge on reset release. Reset mid-frame discards all shifted bits.
- Synchronisation: i_sclk and i_sdin each pass through SYNC_STAGES flops; one more flop holds previous synced sclk. Rising edge = synced sclk 1 and previous 0. Edge is acted on SYNC_STAGES+1 mainclk edges after the i_sclk transition. Protocol requirement: sclk high and low phases each >= SYNC_STAGES+1 mainclk cycles.
- Shift: on each detected edge, shift reg <= {synced sdin, shift reg[NBITS-1:1]}, so first-received bit lands in bit 0. Mapping: o_gainA1 = sreg[GAINA1_W-1:0], o_gainA2 = sreg[NBITS-1:GAINA1_W].
- States:
  sIDLE: edge -> shift bit, bitcnt=1, go sSHIFT. No edge: hold.
  sSHIFT: edge -> shift, bitcnt+1, clear timeout counter. If this is bit NBITS, go sDONE and load gain outputs from the completed shift value in the same cycle. No edge -> timeout counter+1. Reaching TIMEOUT -> go sIDLE, bitcnt=0, o_err=1. Gains unchanged.
  sDONE: o_ready=1, held until reset. Any further edge -> o_err=1. Shift register and gains stay frozen.
- o_ready and gain outputs update together, registered, on the cycle after the final edge is detected. Gains never show partial frames.
- o_err is sticky until reset. A later successful frame sets o_ready but does not clear o_err.
- Edge and timeout expiry in the same cycle: the edge wins and the timeout counter clears.
- Counter widths: bitcnt is clog2(NBITS+1) bits. Timeout counter is clog2(TIMEOUT+1) bits and saturates; it never wraps.

Decomposition:
- Shared package: state encodings sIDLE=0, sSHIFT=1, sDONE=2; default NBITS, GAINA1_W, GAINA2_W, shared with the FPGA model's opcode fields.
- One sub-module: sync_edge_detect, an SYNC_STAGES-deep synchroniser with rising-edge pulse output, instantiated for sclk. The sdin path uses the same depth without edge detection.

Test Plan:
- Reset release with i_sclk=1 held 100 cycles -> no edge detected, all outputs 0, state sIDLE.
- Frame 1,0,1,0,1 (LSB first, 8-cycle sclk phases) -> o_gainA1=1, o_gainA2=5, o_ready=1 four mainclk cycles after the 5th rising edge, o_err=0.
- 3 bits, then sclk held high 64 cycles -> o_err=1, o_ready=0, gains 0. Then frame 0,1,1,1,1 -> o_gainA1=2, o_gainA2=7, o_ready=1, o_err stays 1.
- After a valid frame (gainA1=1, gainA2=5), one extra sclk pulse with sdin=0 -> o_err=1, gains unchanged, o_ready stays 1.
- i_reset pulsed after 2 bits -> all outputs 0 immediately (async). Then full frame 1,1,0,0,1 -> o_gainA1=3, o_gainA2=4, o_ready=1.
- sdin toggles every mainclk while sclk is high, stable only around rising edges, frame 1,0,1,0,1 -> o_gainA1=1, o_gainA2=5.
